spi_pack_fifo: RTL and testbench

- Parametrised single-clock receive buffer for the SPI data-out path.
- Stores DSIZE-bit entries in a 2^ASIZE-deep circular FIFO with proper full/empty, occupancy and overflow flags.
- An output packer drains the FIFO and assembles PACK entries into one wide word, delivered over a valid/ready handshake.
- Supports explicit flush of a partial word with a length indication.

---
 rtl/spi_pack_fifo_if.sv | 36 +++
 rtl/spi_pack_fifo.sv | 135 +++++++++++++
 tb/tb_spi_pack_fifo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pack_fifo_if.sv
`default_nettype none
// ============================================================================
// spi_pack_fifo_if : write side, status flags and packed-word handshake
// Rev 1.0
// ============================================================================
interface spi_pack_fifo_if #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4,
   parameter int PACK  = 15
) ();
   localparam int LW = $clog2(PACK + 1);

   logic                  wr_en;
   logic [DSIZE-1:0]      wdata;
   logic                  full;
   logic                  empty;
   logic [ASIZE:0]        count;
   logic                  overflow;
   logic                  ovf_clr;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [DSIZE*PACK-1:0] data_out;
   logic [LW-1:0]         out_len;

   modport slave (
      input  wr_en, wdata, ovf_clr, flush, out_ready,
      output full, empty, count, overflow, out_valid, data_out, out_len
   );

   modport master (
      output wr_en, wdata, ovf_clr, flush, out_ready,
      input  full, empty, count, overflow, out_valid, data_out, out_len
   );
endinterface
`default_nettype wire

// File: rtl/spi_pack_fifo.sv
`default_nettype none
// ============================================================================
// spi_pack_fifo : circular receive FIFO drained into a PACK-entry wide word
// Rev 1.0
// ============================================================================
module spi_pack_fifo #(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter int PACK      = 15,
   parameter bit LSB_FIRST = 1'b1
) (
   input  wire logic        clk,
   input  wire logic        rst,
   spi_pack_fifo_if.slave   bus
);
   localparam int LW    = $clog2(PACK + 1);
   localparam int DEPTH = 1 << ASIZE;

   typedef enum logic [0:0] {
      S_FILL = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   logic [DSIZE-1:0]      r_mem [DEPTH];
   logic [ASIZE:0]        r_wptr;
   logic [ASIZE:0]        r_rptr;
   logic                  r_ovf;
   state_t                r_state;
   logic [DSIZE*PACK-1:0] r_data;
   logic [LW-1:0]         r_fill;
   logic [LW-1:0]         r_len;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr;
   logic                  w_pop;
   logic [LW-1:0]         w_slot;
   logic [DSIZE-1:0]      w_rdata;
   state_t                w_state_nxt;
   logic [DSIZE*PACK-1:0] w_data_nxt;
   logic [LW-1:0]         w_fill_nxt;
   logic [LW-1:0]         w_len_nxt;

   // Extra pointer MSB distinguishes a full ring from an empty one
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                    (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);
   assign w_wr    = bus.wr_en && !w_full;
   assign w_pop   = !w_empty && (r_state == S_FILL);
   assign w_rdata = r_mem[r_rptr[ASIZE-1:0]];
   assign w_slot  = LSB_FIRST ? r_fill : (LW'(PACK - 1) - r_fill);

   assign bus.full      = w_full;
   assign bus.empty     = w_empty;
   assign bus.count     = r_wptr - r_rptr;
   assign bus.overflow  = r_ovf;
   assign bus.out_valid = (r_state == S_HOLD);
   assign bus.data_out  = r_data;
   assign bus.out_len   = r_len;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr[ASIZE-1:0]] <= bus.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
         end else if (bus.wr_en && w_full) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FILL;
         r_data  <= '0;
         r_fill  <= '0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_fill  <= w_fill_nxt;
         r_len   <= w_len_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_fill_nxt  = r_fill;
      w_len_nxt   = r_len;
      case (r_state)
         S_FILL: begin
            if (w_pop) begin
               w_data_nxt[DSIZE*w_slot +: DSIZE] = w_rdata;
               w_fill_nxt = r_fill + LW'(1);
               if (r_fill == LW'(PACK - 1)) begin
                  w_state_nxt = S_HOLD;
                  w_len_nxt   = LW'(PACK);
               end
            end else if (bus.flush && (r_fill != '0)) begin
               // Flush only takes effect once the FIFO has run dry
               w_state_nxt = S_HOLD;
               w_len_nxt   = r_fill;
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               w_state_nxt = S_FILL;
               w_data_nxt  = '0;
               w_fill_nxt  = '0;
               w_len_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_FILL;
         end
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_spi_pack_fifo.sv
`default_nettype none
// ============================================================================
// tb_spi_pack_fifo : scoreboarded random and directed checks of spi_pack_fifo
// Rev 1.0
// ============================================================================
module tb_spi_pack_fifo;
   localparam int DSIZE = 8;
   localparam int ASIZE = 4;
   localparam int PACK  = 15;
   localparam int DEPTH = 16;

   typedef struct {
      logic [DSIZE*PACK-1:0] d;
      logic [3:0]            len;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_pack_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .PACK(PACK)) u_if ();
   spi_pack_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .PACK(PACK)) u_if2 ();

   spi_pack_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .PACK(PACK), .LSB_FIRST(1'b1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   spi_pack_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .PACK(PACK), .LSB_FIRST(1'b0)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (u_if2.slave)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   // Reference model: byte queue for the FIFO, entry list for the word being built
   logic [7:0] m_fifo[$];
   logic [7:0] m_word[$];
   bit         m_hold = 1'b0;
   bit         m_ovf  = 1'b0;
   exp_t       exp_q[$];

   function automatic exp_t pack_word(logic [7:0] w[$]);
      exp_t e;
      e.d   = '0;
      e.len = 4'(w.size());
      for (int k = 0; k < w.size(); k++) e.d[8*k +: 8] = w[k];
      return e;
   endfunction

   always @(posedge clk) begin : p_model
      bit f, e, pop, hs, fl;
      if (rst) begin
         m_fifo.delete();
         m_word.delete();
         m_hold = 1'b0;
         m_ovf  = 1'b0;
         exp_q.delete();
      end else begin
         f   = (m_fifo.size() == DEPTH);
         e   = (m_fifo.size() == 0);
         pop = !e && !m_hold;
         hs  = m_hold && u_if.out_ready;
         fl  = !m_hold && e && u_if.flush && (m_word.size() > 0);
         if (u_if.ovf_clr) m_ovf = 1'b0;
         else if (u_if.wr_en && f) m_ovf = 1'b1;
         if (pop) m_word.push_back(m_fifo.pop_front());
         if (u_if.wr_en && !f) m_fifo.push_back(u_if.wdata);
         if ((pop && m_word.size() == PACK) || fl) begin
            m_hold = 1'b1;
            exp_q.push_back(pack_word(m_word));
         end
         if (hs) begin
            m_hold = 1'b0;
            m_word.delete();
         end
      end
   end

   always @(negedge clk) begin : p_monitor
      chk("count", 128'(u_if.count), 128'(m_fifo.size()));
      chk("full", 128'(u_if.full), 128'(m_fifo.size() == DEPTH));
      chk("empty", 128'(u_if.empty), 128'(m_fifo.size() == 0));
      chk("overflow", 128'(u_if.overflow), 128'(m_ovf));
      chk("out_valid", 128'(u_if.out_valid), 128'(m_hold));
      if (u_if.out_valid && exp_q.size() > 0) begin
         chk("data_out", 128'(u_if.data_out), 128'(exp_q[0].d));
         chk("out_len", 128'(u_if.out_len), 128'(exp_q[0].len));
      end
      if (u_if.out_valid && u_if.out_ready && !rst) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%0h required=none", u_if.data_out);
         end else begin
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(string name);
      int c = 0;
      while (!u_if.out_valid && c < 100) begin
         tick();
         c++;
      end
      chk(name, 128'(u_if.out_valid), 128'(1));
   endtask

   task automatic wait_empty(string name);
      int c = 0;
      while (!u_if.empty && c < 100) begin
         tick();
         c++;
      end
      chk(name, 128'(u_if.empty), 128'(1));
   endtask

   task automatic write_byte(logic [7:0] b);
      u_if.wr_en = 1'b1;
      u_if.wdata = b;
      tick();
      u_if.wr_en = 1'b0;
   endtask

   initial begin
      int c;
      rst = 1'b1;
      u_if.wr_en = 0; u_if.wdata = 0; u_if.ovf_clr = 0; u_if.flush = 0; u_if.out_ready = 0;
      u_if2.wr_en = 0; u_if2.wdata = 0; u_if2.ovf_clr = 0; u_if2.flush = 0; u_if2.out_ready = 0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_count", 128'(u_if.count), 128'(0));
      chk("rst_empty", 128'(u_if.empty), 128'(1));
      chk("rst_data", 128'(u_if.data_out), 128'(0));
      chk("rst_len", 128'(u_if.out_len), 128'(0));

      // MSB-first variant
      u_if2.out_ready = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         u_if2.wr_en = 1'b1;
         u_if2.wdata = 8'(i);
         tick();
      end
      u_if2.wr_en = 1'b0;
      c = 0;
      while (!u_if2.out_valid && c < 100) begin
         tick();
         c++;
      end
      chk("msb_valid", 128'(u_if2.out_valid), 128'(1));
      chk("msb_data", 128'(u_if2.data_out), 128'(120'h0102030405060708090A0B0C0D0E0F));
      chk("msb_len", 128'(u_if2.out_len), 128'(15));
      tick();

      // Full word, consumer always ready
      u_if.out_ready = 1'b1;
      for (int i = 1; i <= 15; i++) write_byte(8'(i));
      wait_valid("t1_valid");
      chk("t1_data", 128'(u_if.data_out), 128'(120'h0F0E0D0C0B0A090807060504030201));
      chk("t1_len", 128'(u_if.out_len), 128'(15));
      tick();
      tick();
      chk("t1_empty", 128'(u_if.empty), 128'(1));

      // Back-pressure to full and overflow
      u_if.out_ready = 1'b0;
      for (int i = 0; i < 32; i++) write_byte(8'(i));
      chk("t2_count", 128'(u_if.count), 128'(16));
      chk("t2_full", 128'(u_if.full), 128'(1));
      chk("t2_ovf", 128'(u_if.overflow), 128'(1));
      u_if.out_ready = 1'b1;
      wait_empty("t2_drain");
      tick();
      u_if.flush = 1'b1;
      tick();
      u_if.flush = 1'b0;
      tick();
      tick();
      chk("t2_ovf_sticky", 128'(u_if.overflow), 128'(1));
      u_if.ovf_clr = 1'b1;
      tick();
      u_if.ovf_clr = 1'b0;
      chk("t2_ovf_clr", 128'(u_if.overflow), 128'(0));

      // Partial word via flush
      write_byte(8'hAA);
      write_byte(8'hBB);
      write_byte(8'hCC);
      wait_empty("t3_empty");
      tick();
      u_if.flush = 1'b1;
      tick();
      u_if.flush = 1'b0;
      chk("t3_data", 128'(u_if.data_out), 128'(120'hCCBBAA));
      chk("t3_len", 128'(u_if.out_len), 128'(3));
      tick();
      u_if.flush = 1'b1;
      tick();
      u_if.flush = 1'b0;
      tick();
      chk("t3_noflush", 128'(u_if.out_valid), 128'(0));

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         u_if.wr_en     = ($urandom_range(0, 3) != 0);
         u_if.wdata     = 8'($urandom);
         u_if.out_ready = 1'($urandom);
         u_if.flush     = ($urandom_range(0, 15) == 0);
         u_if.ovf_clr   = ($urandom_range(0, 31) == 0);
         tick();
      end
      u_if.wr_en = 0; u_if.ovf_clr = 0;
      u_if.out_ready = 1'b1;
      u_if.flush = 1'b1;
      for (int i = 0; i < 60; i++) tick();
      u_if.flush = 1'b0;
      chk("rand_drained", 128'(u_if.empty && !u_if.out_valid), 128'(1));

      // Reset in the middle of a word
      for (int i = 0; i < 7; i++) write_byte(8'h40 + 8'(i));
      tick();
      tick();
      for (int i = 0; i < 4; i++) write_byte(8'h50 + 8'(i));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_count", 128'(u_if.count), 128'(0));
      chk("mrst_empty", 128'(u_if.empty), 128'(1));
      chk("mrst_valid", 128'(u_if.out_valid), 128'(0));
      chk("mrst_data", 128'(u_if.data_out), 128'(0));
      for (int i = 0; i < 15; i++) write_byte(8'h80 + 8'(i));
      wait_valid("mrst_word");
      chk("mrst_word_data", 128'(u_if.data_out), 128'(120'h8E8D8C8B8A898887868584838281 << 8 | 120'h80));
      for (int i = 0; i < 4; i++) tick();

      chk("sb_pending", 128'(exp_q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
